// File: rtl/cache_axi_bridge_if.sv
// cache_axi_bridge_if
// Single-requester cache_* bus between cache_axi_bridge and the AXI master.
//   master modport : bridge side, drives requests/write data, receives beats
//   slave modport  : AXI master side, returns read beats and write responses
// Signals:
//   cache_ce/ren/rready/raddr/cacher_burst_length : read request
//   cache_wen/wvalid/waddr/wdata/wlast/wsel/cachew_burst_length : write request
//   cache_brust_type/size : fixed INCR, 4-byte beats
//   rdata_i/rdata_valid_i : returned read beat
//   wdata_resp_i          : current write beat consumed
interface cache_axi_bridge_if;
   logic        cache_ce;
   logic        cache_ren;
   logic        cache_rready;
   logic [31:0] cache_raddr;
   logic [7:0]  cacher_burst_length;
   logic        cache_wen;
   logic        cache_wvalid;
   logic [31:0] cache_waddr;
   logic [31:0] cache_wdata;
   logic        cache_wlast;
   logic [3:0]  cache_wsel;
   logic [7:0]  cachew_burst_length;
   logic [1:0]  cache_brust_type;
   logic [2:0]  cache_brust_size;
   logic [31:0] rdata_i;
   logic        rdata_valid_i;
   logic        wdata_resp_i;

   modport master (
      output cache_ce, cache_ren, cache_rready, cache_raddr, cacher_burst_length,
      output cache_wen, cache_wvalid, cache_waddr, cache_wdata, cache_wlast,
      output cache_wsel, cachew_burst_length, cache_brust_type, cache_brust_size,
      input  rdata_i, rdata_valid_i, wdata_resp_i
   );

   modport slave (
      input  cache_ce, cache_ren, cache_rready, cache_raddr, cacher_burst_length,
      input  cache_wen, cache_wvalid, cache_waddr, cache_wdata, cache_wlast,
      input  cache_wsel, cachew_burst_length, cache_brust_type, cache_brust_size,
      output rdata_i, rdata_valid_i, wdata_resp_i
   );
endinterface

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge
// Arbitrates icache refills, dcache refills and dcache writebacks/uncached
// stores onto the single-requester cache_* bus. Read beats are assembled into
// a line buffer; writeback lines are sliced into 32-bit beats.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_rreq/i_raddr      : icache refill request (level) and line address
//   i_rline/i_rvalid    : assembled line and one-cycle completion pulse
//   d_rreq/d_raddr/d_runcached : dcache read request, address, single-word flag
//   d_rline/d_rvalid    : assembled line (uncached word in [31:0]) and pulse
//   d_wreq/d_waddr/d_wline/d_wuncached/d_wsel : dcache write request
//   d_wdone             : one-cycle pulse after the last write beat is consumed
//   bus                 : cache_* bus toward the AXI master (master modport)
// Macro CACHE_AXI_BRIDGE_DPRIO_EN: when defined, dcache always wins a read tie;
// otherwise ties are resolved round-robin.
//
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for a grantable read request
//   R_BUSY | burst in flight, collecting beats into the line buffer
//   R_DONE | completion pulse to the owner is high this cycle
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for d_wreq
//   W_BUSY | beats being handed out, one per wdata_resp_i
module cache_axi_bridge #(
   parameter int LINE_WORDS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_rreq,
   input  logic [31:0]             i_raddr,
   output logic [32*LINE_WORDS-1:0] i_rline,
   output logic                    i_rvalid,
   input  logic                    d_rreq,
   input  logic [31:0]             d_raddr,
   input  logic                    d_runcached,
   output logic [32*LINE_WORDS-1:0] d_rline,
   output logic                    d_rvalid,
   input  logic                    d_wreq,
   input  logic [31:0]             d_waddr,
   input  logic [32*LINE_WORDS-1:0] d_wline,
   input  logic                    d_wuncached,
   input  logic [3:0]              d_wsel,
   output logic                    d_wdone,
   cache_axi_bridge_if.master      bus
);
   localparam int CW = $clog2(LINE_WORDS) + 1;
   localparam int OFF = $clog2(4 * LINE_WORDS);
   localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

   typedef enum logic [1:0] {R_IDLE, R_BUSY, R_DONE} rstate_t;
   typedef enum logic {W_IDLE, W_BUSY} wstate_t;

   rstate_t                        r_rstate;
   logic [CW-1:0]                  r_rcnt;
   logic [LINE_WORDS-1:0][31:0]    r_rbuf;
   logic [31:0]                    r_raddr;
   logic [7:0]                     r_rlen;
   logic                           r_ren;
   logic                           r_rowner_d;
   logic                           r_irvalid;
   logic                           r_drvalid;

   wstate_t                        r_wstate;
   logic [CW-1:0]                  r_wcnt;
   logic [LINE_WORDS-1:0][31:0]    r_wbuf;
   logic [31:0]                    r_waddr;
   logic [7:0]                     r_wlen;
   logic [3:0]                     r_wsel;
   logic                           r_wen;
   logic                           r_wdone;

   logic                           w_pick_d;
   logic [31:0]                    w_gaddr;
   logic                           w_hazard;
   logic                           w_grant;
   logic                           w_wlast;

`ifdef CACHE_AXI_BRIDGE_DPRIO_EN
   always_comb w_pick_d = d_rreq;
`else
   // r_prio_d is set when the icache won the previous grant, so a tie goes to dcache.
   logic r_prio_d;
   always_comb w_pick_d = d_rreq & (~i_rreq | r_prio_d);

   always_ff @(posedge clk) begin
      if (rst)          r_prio_d <= 1'b0;
      else if (w_grant) r_prio_d <= ~w_pick_d;
   end
`endif

   always_comb begin
      w_gaddr  = w_pick_d ? d_raddr : i_raddr;
      // Reads to a line that is being written back must wait for the write to drain.
      w_hazard = (r_wstate == W_BUSY) && (w_gaddr[31:OFF] == r_waddr[31:OFF]);
      w_grant  = (r_rstate == R_IDLE) && (i_rreq | d_rreq) && !w_hazard;
      w_wlast  = (r_wstate == W_BUSY) && (8'(r_wcnt) == r_wlen);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rstate   <= R_IDLE;
         r_rcnt     <= '0;
         r_rbuf     <= '0;
         r_raddr    <= '0;
         r_rlen     <= '0;
         r_ren      <= 1'b0;
         r_rowner_d <= 1'b0;
         r_irvalid  <= 1'b0;
         r_drvalid  <= 1'b0;
      end else begin
         r_irvalid <= 1'b0;
         r_drvalid <= 1'b0;
         case (r_rstate)
            R_IDLE: if (w_grant) begin
               r_rstate   <= R_BUSY;
               r_raddr    <= w_gaddr;
               r_rowner_d <= w_pick_d;
               r_rlen     <= (w_pick_d && d_runcached) ? 8'd0 : LINE_LEN;
               r_rcnt     <= '0;
               r_ren      <= 1'b1;
            end
            R_BUSY: if (bus.rdata_valid_i) begin
               r_rbuf[r_rcnt[CW-2:0]] <= bus.rdata_i;
               r_rcnt <= r_rcnt + CW'(1);
               if (8'(r_rcnt) == r_rlen) begin
                  r_rstate  <= R_DONE;
                  r_ren     <= 1'b0;
                  r_irvalid <= ~r_rowner_d;
                  r_drvalid <= r_rowner_d;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wstate <= W_IDLE;
         r_wcnt   <= '0;
         r_wbuf   <= '0;
         r_waddr  <= '0;
         r_wlen   <= '0;
         r_wsel   <= '0;
         r_wen    <= 1'b0;
         r_wdone  <= 1'b0;
      end else begin
         r_wdone <= 1'b0;
         case (r_wstate)
            W_IDLE: if (d_wreq) begin
               r_wstate <= W_BUSY;
               r_waddr  <= d_waddr;
               r_wbuf   <= d_wline;
               r_wsel   <= d_wuncached ? d_wsel : 4'b1111;
               r_wlen   <= d_wuncached ? 8'd0 : LINE_LEN;
               r_wcnt   <= '0;
               r_wen    <= 1'b1;
            end
            default: if (bus.wdata_resp_i) begin
               r_wcnt <= r_wcnt + CW'(1);
               if (w_wlast) begin
                  r_wstate <= W_IDLE;
                  r_wen    <= 1'b0;
                  r_wdone  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign i_rline  = r_rbuf;
   assign d_rline  = r_rbuf;
   assign i_rvalid = r_irvalid;
   assign d_rvalid = r_drvalid;
   assign d_wdone  = r_wdone;

   assign bus.cache_ce            = r_ren | r_wen;
   assign bus.cache_ren           = r_ren;
   assign bus.cache_rready        = r_ren;
   assign bus.cache_raddr         = r_raddr;
   assign bus.cacher_burst_length = r_rlen;
   assign bus.cache_wen           = r_wen;
   assign bus.cache_wvalid        = r_wen;
   assign bus.cache_waddr         = r_waddr;
   assign bus.cache_wdata         = r_wbuf[r_wcnt[CW-2:0]];
   assign bus.cache_wlast         = w_wlast;
   assign bus.cache_wsel          = r_wsel;
   assign bus.cachew_burst_length = r_wlen;
   assign bus.cache_brust_type    = 2'b01;
   assign bus.cache_brust_size    = 3'b010;
endmodule

// File: tb/tb_cache_axi_bridge.sv
module tb_cache_axi_bridge;
   logic         clk = 1'b0;
   logic         rst;
   logic         i_rreq, d_rreq, d_runcached, d_wreq, d_wuncached;
   logic [31:0]  i_raddr, d_raddr, d_waddr;
   logic [127:0] i_rline, d_rline, d_wline;
   logic         i_rvalid, d_rvalid, d_wdone;
   logic [3:0]   d_wsel;
   int           total = 0;
   int           passed = 0;
   int           fails = 0;
   logic         first_d, second_d;

   cache_axi_bridge_if bus();

   cache_axi_bridge #(.LINE_WORDS(4)) dut (
      .clk(clk), .rst(rst),
      .i_rreq(i_rreq), .i_raddr(i_raddr), .i_rline(i_rline), .i_rvalid(i_rvalid),
      .d_rreq(d_rreq), .d_raddr(d_raddr), .d_runcached(d_runcached),
      .d_rline(d_rline), .d_rvalid(d_rvalid),
      .d_wreq(d_wreq), .d_waddr(d_waddr), .d_wline(d_wline),
      .d_wuncached(d_wuncached), .d_wsel(d_wsel), .d_wdone(d_wdone),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns beats word 0 first, one per cycle.
   task automatic feed(input logic [127:0] line, input int n);
      for (int k = 0; k < n; k++) begin
         bus.rdata_i       = line[32*k +: 32];
         bus.rdata_valid_i = 1'b1;
         tick();
      end
      bus.rdata_valid_i = 1'b0;
   endtask

   initial begin
`ifdef CACHE_AXI_BRIDGE_DPRIO_EN
      first_d = 1'b1; second_d = 1'b1;
`else
      first_d = 1'b0; second_d = 1'b1;
`endif
      rst = 1'b1;
      i_rreq = 0; d_rreq = 0; d_runcached = 0; d_wreq = 0; d_wuncached = 0;
      i_raddr = 0; d_raddr = 0; d_waddr = 0; d_wline = 0; d_wsel = 0;
      bus.rdata_i = 0; bus.rdata_valid_i = 0; bus.wdata_resp_i = 0;
      tick(); tick();
      chk("rst_ce", bus.cache_ce, 0);
      chk("rst_ren", bus.cache_ren, 0);
      chk("rst_wen", bus.cache_wen, 0);
      chk("rst_wlast", bus.cache_wlast, 0);
      chk("rst_wdata", bus.cache_wdata, 0);
      chk("rst_rlen", bus.cacher_burst_length, 0);
      chk("rst_btype", bus.cache_brust_type, 2'b01);
      chk("rst_bsize", bus.cache_brust_size, 3'b010);
      chk("rst_pulses", {i_rvalid, d_rvalid, d_wdone}, 0);
      rst = 1'b0;
      tick();

      // icache refill
      i_rreq = 1; i_raddr = 32'h1C000040;
      tick();
      chk("ic_ren", bus.cache_ren, 1);
      chk("ic_ce", bus.cache_ce, 1);
      chk("ic_raddr", bus.cache_raddr, 32'h1C000040);
      chk("ic_len", bus.cacher_burst_length, 3);
      feed({32'h44, 32'h33, 32'h22, 32'h11}, 3);
      chk("ic_no_early_pulse", i_rvalid, 0);
      feed({96'h0, 32'h44}, 1);
      chk("ic_rvalid", i_rvalid, 1);
      chk("ic_d_rvalid", d_rvalid, 0);
      chk("ic_rline", i_rline, {32'h44, 32'h33, 32'h22, 32'h11});
      chk("ic_ren_off", bus.cache_ren, 0);
      i_rreq = 0;
      bus.rdata_i = 32'h99; bus.rdata_valid_i = 1;
      tick();
      bus.rdata_valid_i = 0;
      chk("ic_pulse_end", i_rvalid, 0);
      chk("ic_stray_beat", i_rline, {32'h44, 32'h33, 32'h22, 32'h11});
      tick();

      // uncached dcache read
      d_rreq = 1; d_raddr = 32'hBFAF8000; d_runcached = 1;
      tick();
      chk("unc_len", bus.cacher_burst_length, 0);
      chk("unc_raddr", bus.cache_raddr, 32'hBFAF8000);
      feed({96'h0, 32'hDEADBEEF}, 1);
      chk("unc_rvalid", d_rvalid, 1);
      chk("unc_i_rvalid", i_rvalid, 0);
      chk("unc_data", d_rline[31:0], 32'hDEADBEEF);
      d_rreq = 0; d_runcached = 0;
      tick();
      chk("unc_pulse_end", d_rvalid, 0);

      // writeback, responses on alternate cycles
      d_wreq = 1; d_waddr = 32'h00001000; d_wuncached = 0; d_wsel = 4'hF;
      d_wline = {32'd4, 32'd3, 32'd2, 32'd1};
      tick();
      chk("wb_wen", bus.cache_wen, 1);
      chk("wb_wvalid", bus.cache_wvalid, 1);
      chk("wb_waddr", bus.cache_waddr, 32'h1000);
      chk("wb_len", bus.cachew_burst_length, 3);
      chk("wb_wsel", bus.cache_wsel, 4'hF);
      for (int k = 0; k < 4; k++) begin
         chk("wb_wdata", bus.cache_wdata, 32'(k + 1));
         chk("wb_wlast", bus.cache_wlast, (k == 3));
         bus.wdata_resp_i = 1;
         tick();
         bus.wdata_resp_i = 0;
         if (k < 3) begin
            chk("wb_no_early_done", d_wdone, 0);
            tick();
         end
      end
      chk("wb_done", d_wdone, 1);
      chk("wb_wen_off", bus.cache_wen, 0);
      d_wreq = 0;
      tick();
      chk("wb_done_end", d_wdone, 0);

      // uncached store
      d_wreq = 1; d_waddr = 32'hBFD00000; d_wuncached = 1; d_wsel = 4'b0100;
      d_wline = {96'h0, 32'h00AB0000};
      tick();
      chk("us_len", bus.cachew_burst_length, 0);
      chk("us_wsel", bus.cache_wsel, 4'b0100);
      chk("us_wlast", bus.cache_wlast, 1);
      chk("us_wdata", bus.cache_wdata, 32'h00AB0000);
      bus.wdata_resp_i = 1;
      tick();
      bus.wdata_resp_i = 0;
      chk("us_done", d_wdone, 1);
      d_wreq = 0; d_wuncached = 0;
      tick();

      // read-after-write hazard
      d_wreq = 1; d_waddr = 32'h00001000; d_wsel = 4'hF;
      d_wline = {32'hC4, 32'hC3, 32'hC2, 32'hC1};
      tick();
      chk("hz_wen", bus.cache_wen, 1);
      i_rreq = 1; i_raddr = 32'h00002000;
      tick();
      chk("hz_other_line_granted", bus.cache_ren, 1);
      chk("hz_other_raddr", bus.cache_raddr, 32'h2000);
      feed({32'h5, 32'h6, 32'h7, 32'h8}, 4);
      chk("hz_other_rvalid", i_rvalid, 1);
      i_rreq = 0;
      tick();
      d_rreq = 1; d_raddr = 32'h00001008;
      tick();
      chk("hz_blocked1", bus.cache_ren, 0);
      tick();
      chk("hz_blocked2", bus.cache_ren, 0);
      bus.wdata_resp_i = 1;
      tick(); tick(); tick(); tick();
      bus.wdata_resp_i = 0;
      chk("hz_wdone", d_wdone, 1);
      chk("hz_still_blocked", bus.cache_ren, 0);
      d_wreq = 0;
      tick();
      chk("hz_granted", bus.cache_ren, 1);
      chk("hz_raddr", bus.cache_raddr, 32'h1008);
      feed({32'hD4, 32'hD3, 32'hD2, 32'hD1}, 4);
      chk("hz_rvalid", d_rvalid, 1);
      chk("hz_rline", d_rline, {32'hD4, 32'hD3, 32'hD2, 32'hD1});
      d_rreq = 0;
      tick();

      // simultaneous requests, both held so the second tie follows directly
      i_rreq = 1; i_raddr = 32'h3000; d_rreq = 1; d_raddr = 32'h4000;
      tick();
      chk("tie1_raddr", bus.cache_raddr, first_d ? 32'h4000 : 32'h3000);
      feed({32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4);
      chk("tie1_i_rvalid", i_rvalid, !first_d);
      chk("tie1_d_rvalid", d_rvalid, first_d);
      tick();
      chk("tie_gap", bus.cache_ren, 0);
      tick();
      chk("tie2_ren", bus.cache_ren, 1);
      chk("tie2_raddr", bus.cache_raddr, second_d ? 32'h4000 : 32'h3000);
      feed({32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4);
      chk("tie2_d_rvalid", d_rvalid, second_d);
      chk("tie2_rline", d_rline, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
      i_rreq = 0; d_rreq = 0;
      tick();

      // reset in the middle of a read and a write
      d_wreq = 1; d_waddr = 32'h8000; d_wline = {32'h1, 32'h2, 32'h3, 32'h4};
      i_rreq = 1; i_raddr = 32'h9000;
      tick();
      d_wreq = 0;
      feed({64'h0, 32'hE2, 32'hE1}, 2);
      rst = 1;
      tick();
      rst = 0;
      chk("mrst_ren", bus.cache_ren, 0);
      chk("mrst_wen", bus.cache_wen, 0);
      chk("mrst_pulses", {i_rvalid, d_rvalid, d_wdone}, 0);
      chk("mrst_rline", i_rline, 0);
      i_rreq = 0;
      tick();
      chk("mrst_no_pulse", {i_rvalid, d_rvalid, d_wdone}, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
